// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Bundles the three channels around the ALU issue controller:
//     request  : req_valid/req_ready/req_funct/req_a/req_b (pipeline -> ctrl)
//     response : rsp_valid/rsp_ready/rsp_data              (ctrl -> pipeline)
//     ALU      : alu_a/alu_b/alu_signal out, alu_dataOut in
//     status   : hilo_done, div_zero pulses; dbg_state exposes the FSM state
//   Handshake rule for both valid/ready channels: a transfer happens on a
//   rising clock edge where valid and ready are both high. Once raised, valid
//   and its payload stay stable until that transfer happens.
//   Modports: slave = the issue controller, master = the environment
//   (pipeline plus ALU complex) that talks to it.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_funct;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [5:0]       alu_signal;
    logic [WIDTH-1:0] alu_dataOut;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             hilo_done;
    logic             div_zero;
    logic [1:0]       dbg_state;

    modport slave (
        input  req_valid, req_funct, req_a, req_b, rsp_ready, alu_dataOut,
        output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_signal,
               hilo_done, div_zero, dbg_state
    );

    modport master (
        output req_valid, req_funct, req_a, req_b, rsp_ready, alu_dataOut,
        input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_signal,
               hilo_done, div_zero, dbg_state
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the ALU operand/function interface. Accepts one decoded
//   op at a time, drives operands and function code to the ALU, holds them
//   through the ALU latency (or the full divide time for DIVU), captures the
//   ALU result and hands it back over a valid/ready response channel.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : alu_issue_ctrl_if.slave (request, response, ALU and status signals)
// Configuration
//   ALU_ISSUE_DIVZERO_EN : when defined, a DIVU with a zero divisor is not
//   issued to the divider; div_zero pulses instead. Otherwise div_zero is 0.
module alu_issue_ctrl #(
    parameter int         WIDTH      = 32,
    parameter int         ALU_LAT    = 1,
    parameter int         DIV_CYCLES = 32,
    parameter logic [5:0] NOP_FUNCT  = 6'h3F,
    parameter logic [5:0] DIVU_FUNCT = 6'd27
) (
    input logic             clk,
    input logic             reset,
    alu_issue_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam int MAX_CNT = (DIV_CYCLES > ALU_LAT) ? DIV_CYCLES : ALU_LAT;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [5:0]       alu_signal_q, alu_signal_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             hilo_done_q, hilo_done_d;
    logic             div_zero_hit;

`ifdef ALU_ISSUE_DIVZERO_EN
    logic div_zero_q, div_zero_d;
    assign div_zero_hit = (bus.req_funct == DIVU_FUNCT) && (bus.req_b == '0);
    assign div_zero_d   = (state_q == S_IDLE) && bus.req_valid && div_zero_hit;
    assign bus.div_zero = div_zero_q;
`else
    assign div_zero_hit = 1'b0;
    assign bus.div_zero = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_signal_d = alu_signal_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        hilo_done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A zero-divisor DIVU is swallowed here: the divider keeps
                // seeing NOP so Hi/Lo are untouched, and we stay ready.
                if (bus.req_valid && !div_zero_hit) begin
                    alu_a_d      = bus.req_a;
                    alu_b_d      = bus.req_b;
                    alu_signal_d = bus.req_funct;
                    if (bus.req_funct == DIVU_FUNCT) begin
                        state_d = S_DIV;
                        cnt_d   = DIV_LOAD;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = EXEC_LOAD;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    rsp_data_d   = bus.alu_dataOut;
                    rsp_valid_d  = 1'b1;
                    alu_signal_d = NOP_FUNCT;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                // DIVU must be held for the whole divide; dropping to NOP
                // marks completion and Hi/Lo are valid from the next cycle.
                if (cnt_q == '0) begin
                    alu_signal_d = NOP_FUNCT;
                    hilo_done_d  = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_signal_q <= NOP_FUNCT;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            hilo_done_q  <= 1'b0;
`ifdef ALU_ISSUE_DIVZERO_EN
            div_zero_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_signal_q <= alu_signal_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            hilo_done_q  <= hilo_done_d;
`ifdef ALU_ISSUE_DIVZERO_EN
            div_zero_q   <= div_zero_d;
`endif
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_signal = alu_signal_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.hilo_done  = hilo_done_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic clk;
  logic reset;
  int checks = 0;
  int errors = 0;

  alu_issue_ctrl_if #(.WIDTH(32)) bus ();

  alu_issue_ctrl #(
    .WIDTH(32), .ALU_LAT(1), .DIV_CYCLES(32),
    .NOP_FUNCT(6'h3F), .DIVU_FUNCT(6'd27)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU complex model ----------------
  logic [31:0] hi_r = 32'd0;
  logic [31:0] lo_r = 32'd0;
  logic [31:0] div_a_r = 32'd0;
  logic [31:0] div_b_r = 32'd0;
  int div_cycles_seen = 0;

  always_comb begin
    case (bus.alu_signal)
      6'd32:   bus.alu_dataOut = bus.alu_a + bus.alu_b;
      6'd34:   bus.alu_dataOut = bus.alu_a - bus.alu_b;
      6'd16:   bus.alu_dataOut = hi_r;
      6'd18:   bus.alu_dataOut = lo_r;
      default: bus.alu_dataOut = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.alu_signal == 6'd27) begin
      div_cycles_seen <= div_cycles_seen + 1;
      div_a_r <= bus.alu_a;
      div_b_r <= bus.alu_b;
    end
    if (bus.hilo_done) begin
      hi_r <= (div_b_r == 0) ? div_a_r : div_a_r % div_b_r;
      lo_r <= (div_b_r == 0) ? 32'hFFFF_FFFF : div_a_r / div_b_r;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns #1 after the edge that accepted it.
  task automatic issue(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    int n;
    bus.req_valid = 1'b1;
    bus.req_funct = funct;
    bus.req_a     = a;
    bus.req_b     = b;
    n = 0;
    do begin
      rdy = bus.req_ready;
      tick();
      n++;
    end while (!rdy && n < 100);
    bus.req_valid = 1'b0;
    chk("accept_in_time", {31'd0, rdy}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_funct = 6'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    reset = 1'b0;
    #23;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_alu_signal", {26'd0, bus.alu_signal}, 32'h3F);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_hilo_done", {31'd0, bus.hilo_done}, 32'd0);
    chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // ADD 5+7 with consumer ready
    bus.rsp_ready = 1'b1;
    issue(6'd32, 32'd5, 32'd7);
    chk("add_signal", {26'd0, bus.alu_signal}, 32'd32);
    chk("add_alu_a", bus.alu_a, 32'd5);
    chk("add_alu_b", bus.alu_b, 32'd7);
    chk("add_busy", {31'd0, bus.req_ready}, 32'd0);
    chk("add_no_rsp_yet", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("add_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("add_rsp_data", bus.rsp_data, 32'd12);
    chk("add_signal_nop", {26'd0, bus.alu_signal}, 32'h3F);
    chk("add_busy_resp", {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk("add_rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
    chk("add_ready_back", {31'd0, bus.req_ready}, 32'd1);

    // SUB 10-3 with back-pressure; a competing request must be ignored
    bus.rsp_ready = 1'b0;
    issue(6'd34, 32'd10, 32'd3);
    tick();
    bus.req_valid = 1'b1;
    bus.req_funct = 6'd32;
    bus.req_a     = 32'd1;
    bus.req_b     = 32'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_data", bus.rsp_data, 32'd7);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_released", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, bus.req_ready}, 32'd1);
    chk("bp_signal_nop", {26'd0, bus.alu_signal}, 32'h3F);

    // DIVU 100/7 with MFHI waiting during the divide
    div_cycles_seen = 0;
    issue(6'd27, 32'd100, 32'd7);
    chk("div_signal", {26'd0, bus.alu_signal}, 32'd27);
    bus.req_valid = 1'b1;
    bus.req_funct = 6'd16;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    n = 0;
    while (!bus.hilo_done && n < 100) begin
      chk("div_busy", {31'd0, bus.req_ready}, 32'd0);
      chk("div_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
      n++;
    end
    chk("div_len", 32'(n), 32'd32);
    chk("div_hilo_done", {31'd0, bus.hilo_done}, 32'd1);
    chk("div_ready_at_done", {31'd0, bus.req_ready}, 32'd1);
    chk("div_signal_nop", {26'd0, bus.alu_signal}, 32'h3F);
    chk("div_rsp_none", {31'd0, bus.rsp_valid}, 32'd0);
    chk("div_signal_cycles", 32'(div_cycles_seen), 32'd32);
    tick();
    bus.req_valid = 1'b0;
    chk("hilo_pulse_once", {31'd0, bus.hilo_done}, 32'd0);
    chk("mfhi_accepted", {26'd0, bus.alu_signal}, 32'd16);
    tick();
    chk("mfhi_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("mfhi_data", bus.rsp_data, 32'd2);
    tick();
    chk("mfhi_done", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("mfhi_once", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mfhi_once_idle", {31'd0, bus.req_ready}, 32'd1);
    issue(6'd18, 32'd0, 32'd0);
    tick();
    chk("mflo_data", bus.rsp_data, 32'd14);
    tick();

    // DIVU with zero divisor
    div_cycles_seen = 0;
    issue(6'd27, 32'd55, 32'd0);
`ifdef ALU_ISSUE_DIVZERO_EN
    chk("dz_pulse", {31'd0, bus.div_zero}, 32'd1);
    chk("dz_signal_nop", {26'd0, bus.alu_signal}, 32'h3F);
    chk("dz_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    chk("dz_pulse_end", {31'd0, bus.div_zero}, 32'd0);
    chk("dz_no_hilo", {31'd0, bus.hilo_done}, 32'd0);
    chk("dz_never_27", 32'(div_cycles_seen), 32'd0);
    issue(6'd18, 32'd0, 32'd0);
    tick();
    chk("dz_mflo_prior", bus.rsp_data, 32'd14);
    tick();
`else
    chk("dz_signal_27", {26'd0, bus.alu_signal}, 32'd27);
    n = 0;
    while (!bus.hilo_done && n < 100) begin
      chk("dz_no_pulse", {31'd0, bus.div_zero}, 32'd0);
      tick();
      n++;
    end
    chk("dz_len", 32'(n), 32'd32);
    chk("dz_hilo_done", {31'd0, bus.hilo_done}, 32'd1);
    tick();
`endif

    // Reset in the middle of an EXEC op
    bus.rsp_ready = 1'b0;
    issue(6'd32, 32'd1, 32'd2);
    reset = 1'b0;
    #1;
    chk("rstx_signal", {26'd0, bus.alu_signal}, 32'h3F);
    chk("rstx_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rstx_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstx_alu_a", bus.alu_a, 32'd0);
    #3;
    reset = 1'b1;
    tick();
    tick();
    chk("rstx_no_stale_rsp", {31'd0, bus.rsp_valid}, 32'd0);

    // Reset in the middle of a divide
    issue(6'd27, 32'd9, 32'd2);
    tick();
    reset = 1'b0;
    #1;
    chk("rstd_signal", {26'd0, bus.alu_signal}, 32'h3F);
    #3;
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.hilo_done) n++;
      tick();
    end
    chk("rstd_no_hilo", 32'(n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
